// File: rtl/param_cmd_fifo.sv
// Command FIFO for parameter_controller, programmed over the picorv32 native bus.
// Firmware writes an ID, then a VALUE; each full-word VALUE write queues one {id, value} command.
module param_cmd_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_8030,
    parameter int          DEPTH     = 8,
    parameter int          AW        = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        par_valid,
    output logic [7:0]  par_id,
    output logic [31:0] par_value,
    input  logic        par_ready,
    output logic        fifo_irq
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Handshake: the head command transfers on every rising edge where
    // par_valid && par_ready; while par_valid && !par_ready it is held stable.

    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   id_reg, last_value;
    logic          overflow, irq_en;

    logic        hit, accept, is_wr, push_req, pop, do_push, ovf_set, full, empty;
    logic [1:0]  reg_sel;
    logic [31:0] status, rdata_next;
    logic        unused_addr_bits;

    assign unused_addr_bits = &{1'b0, mem_addr[1:0]};

    assign reg_sel  = mem_addr[3:2];
    assign hit      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]) && (reg_sel != 2'd3);
    assign accept   = hit && !mem_ready;
    assign is_wr    = |mem_wstrb;
    assign push_req = accept && (reg_sel == 2'd1) && (mem_wstrb == 4'hF);

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign par_valid = !empty;
    assign pop       = par_valid && par_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_push   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;

    assign {par_id, par_value} = mem[rd_ptr];

    always_comb begin
        status         = '0;
        status[0]      = full;
        status[1]      = empty;
        status[2]      = overflow;
        status[3]      = irq_en;
        status[AW+8:8] = count;
    end

    always_comb begin
        rdata_next = '0;
        unique case (reg_sel)
            2'd0:    rdata_next = id_reg;
            2'd1:    rdata_next = last_value;
            2'd2:    rdata_next = status;
            default: rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && !is_wr) ? rdata_next : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_reg     <= '0;
            last_value <= '0;
            overflow   <= 1'b0;
            irq_en     <= 1'b0;
        end else begin
            if (accept && (reg_sel == 2'd0)) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) id_reg[8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
            if (push_req) last_value <= mem_wdata;
            if (accept && (reg_sel == 2'd2) && mem_wstrb[0]) begin
                if (mem_wdata[2]) overflow <= 1'b0;
                irq_en <= mem_wdata[3];
            end
            if (ovf_set) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {id_reg[7:0], mem_wdata};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_irq <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            fifo_irq <= irq_en && empty;
        end
    end

endmodule

// File: tb/tb_param_cmd_fifo.sv
// Directed bench for param_cmd_fifo: bus driver tasks feed expected queues,
// negedge monitors pop and compare whenever the DUT presents data.
module tb_param_cmd_fifo;

    localparam logic [31:0] ID_A  = 32'h0000_8030;
    localparam logic [31:0] VAL_A = 32'h0000_8034;
    localparam logic [31:0] ST_A  = 32'h0000_8038;
    localparam logic [31:0] BAD_A = 32'h0000_803C;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        par_valid;
    logic [7:0]  par_id;
    logic [31:0] par_value;
    logic        par_ready;
    logic        fifo_irq;

    logic [39:0] exp_q[$];
    logic [31:0] rd_q[$];
    int n_pass;
    int n_total;

    param_cmd_fifo dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .par_valid (par_valid),
        .par_id    (par_id),
        .par_value (par_value),
        .par_ready (par_ready),
        .fifo_irq  (fifo_irq)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // monitors: bus read data and consumer-side commands
    always @(negedge clk) begin
        if (mem_ready) begin
            if (rd_q.size() == 0) check("rdata_unexpected_ack", 1, 0);
            else check("rdata", mem_rdata, rd_q.pop_front());
        end else begin
            check("rdata_idle_zero", mem_rdata, 0);
        end
        if (par_valid && par_ready) begin
            if (exp_q.size() == 0) check("cmd_unexpected_pop", {par_id, par_value}, 0);
            else check("cmd", {par_id, par_value}, exp_q.pop_front());
        end
    end

    // driver tasks; all start and end at #1 after a rising edge
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_rd, input bit pop_same);
        int n;
        rd_q.push_back(exp_rd);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        if (pop_same) par_ready = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!mem_ready && n < 10);
        check("ack", mem_ready, 1);
        if (pop_same) par_ready = 1'b0;
        if (!mem_ready) begin
            void'(rd_q.pop_back());
            mem_valid = 1'b0;
            return;
        end
        if (a == VAL_A && s == 4'hF) check("push_latency", par_valid, 1);
        @(posedge clk);
        #1;
        check("ack_one_cycle", mem_ready, 0);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_wdata = '0;
    endtask

    task automatic cmd(input logic [7:0] id, input logic [31:0] val, input bit stored);
        bus(ID_A, {24'h0, id}, 4'hF, 32'h0, 1'b0);
        if (stored) exp_q.push_back({id, val});
        bus(VAL_A, val, 4'hF, 32'h0, 1'b0);
    endtask

    task automatic drain(input int n);
        par_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        par_ready = 1'b0;
        check("drained_empty", par_valid, 0);
        check("drained_all_expected", exp_q.size(), 0);
    endtask

    task automatic no_ack(input logic [31:0] a);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wstrb = 4'h0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("no_ack", mem_ready, 0);
        end
        mem_valid = 1'b0;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
        par_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_ready", mem_ready, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_par_valid", par_valid, 0);
        check("rst_fifo_irq", fifo_irq, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0002, 1'b0);

        // single command
        cmd(8'h15, 32'h0000_1234, 1'b1);
        check("single_id", par_id, 8'h15);
        check("single_value", par_value, 32'h0000_1234);
        par_ready = 1'b1;
        @(posedge clk);
        #1;
        par_ready = 1'b0;
        check("single_popped", par_valid, 0);
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0002, 1'b0);

        // back-pressure and ordering
        cmd(8'h01, 32'h0000_00A1, 1'b1);
        cmd(8'h02, 32'h0000_00A2, 1'b1);
        cmd(8'h03, 32'h0000_00A3, 1'b1);
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0300, 1'b0);
        check("held_id", par_id, 8'h01);
        check("held_value", par_value, 32'h0000_00A1);
        drain(3);

        // overflow: ninth push dropped
        for (int i = 0; i < 9; i++) cmd(8'h10 + 8'(i), 32'h1000 + 32'(i), i < 8);
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0805, 1'b0);
        bus(ST_A, 32'h4, 4'h1, 32'h0, 1'b0);
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0801, 1'b0);
        drain(8);

        // full with simultaneous pop: ninth push accepted
        for (int i = 0; i < 8; i++) cmd(8'h20 + 8'(i), 32'h2000 + 32'(i), 1'b1);
        bus(ID_A, 32'h28, 4'hF, 32'h0, 1'b0);
        exp_q.push_back({8'h28, 32'h0000_2028});
        bus(VAL_A, 32'h0000_2028, 4'hF, 32'h0, 1'b1);
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0801, 1'b0);
        drain(8);

        // bus rules
        bus(VAL_A, 32'h0000_DEAD, 4'b0011, 32'h0, 1'b0);
        check("partial_strobe_no_push", par_valid, 0);
        bus(VAL_A, 32'h0, 4'h0, 32'h0000_2028, 1'b0);
        bus(ID_A, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0);
        bus(ID_A, 32'h1122_3344, 4'b0101, 32'h0, 1'b0);
        bus(ID_A, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0);
        no_ack(BAD_A);

        // irq and reset mid-operation
        bus(ST_A, 32'h8, 4'h1, 32'h0, 1'b0);
        check("irq_on_empty", fifo_irq, 1);
        cmd(8'h31, 32'h0000_3001, 1'b1);
        check("irq_off_after_push", fifo_irq, 0);
        cmd(8'h32, 32'h0000_3002, 1'b1);
        cmd(8'h33, 32'h0000_3003, 1'b1);
        cmd(8'h34, 32'h0000_3004, 1'b1);
        mem_valid = 1'b1;
        mem_addr  = ST_A;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("ack_before_reset", mem_ready, 1);
        check("queued_before_reset", par_valid, 1);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        exp_q.delete();
        #1;
        check("rst_drop_mem_ready", mem_ready, 0);
        check("rst_drop_mem_rdata", mem_rdata, 0);
        check("rst_drop_par_valid", par_valid, 0);
        check("rst_drop_fifo_irq", fifo_irq, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        bus(ST_A, 32'h0, 4'h0, 32'h0000_0002, 1'b0);
        check("post_reset_irq", fifo_irq, 0);
        cmd(8'h41, 32'h0000_4100, 1'b1);
        drain(1);

        @(posedge clk);
        #1;
        check("rd_q_empty", rd_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
